adc733_emu: RTL and testbench

ADC733_EMU -- requirements
Module: adc733_emu

---
 rtl/adc733_pkg.sv | 24 ++
 rtl/adc733_sclk_gen.sv | 39 +++
 rtl/adc733_emu.sv | 205 ++++++++++++++++++++
 tb/tb_adc733_emu.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc733_pkg.sv
// Shared types and control-word field positions for the ADC733 serial-port emulator.
package adc733_pkg;

    typedef enum logic {
        RX_IDLE,
        RX_SHIFT
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SYNC,
        TX_DATA,
        TX_GAP
    } tx_state_t;

    localparam int CW_BITS    = 16;
    localparam int CW_CD_BIT  = 15;
    localparam int CW_RW_BIT  = 14;
    localparam int CW_ADDR_HI = 10;
    localparam int CW_ADDR_LO = 8;
    localparam int CW_DATA_HI = 7;
    localparam int CW_DATA_LO = 0;

endpackage

// File: rtl/adc733_sclk_gen.sv
// Serial clock generator: SCLK toggles every SCLK_DIV clk while enabled; the strobes mark
// the clk cycle at whose end SCLK rises or falls.
module adc733_sclk_gen #(
    parameter int SCLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst_l,
    input  logic i_se,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall
);
    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic             r_sclk;
    logic             w_tick;

    assign w_tick = i_se && (r_div == DIV_W'(SCLK_DIV - 1));
    assign o_rise = w_tick && !r_sclk;
    assign o_fall = w_tick && r_sclk;
    assign o_sclk = r_sclk;

    always_ff @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
        end else if (!i_se) begin
            r_div  <= '0;
            r_sclk <= 1'b0;
        end else if (w_tick) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_div  <= r_div + 1'b1;
        end
    end

endmodule

// File: rtl/adc733_emu.sv
// ADC733 serial-port emulator: control-word receiver, register file and framed sample transmitter.
// Define ADC733_EMU_RAMP_EN to transmit per-channel ramp counters instead of sample_data.
module adc733_emu
    import adc733_pkg::*;
#(
    parameter int SCLK_DIV  = 2,
    parameter int FRAME_GAP = 4,
    parameter int NUM_CH    = 6
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        SE,
    output logic        SCLK,
    input  logic        SDIFS,
    input  logic        SDI,
    output logic        SDOFS,
    output logic        SDO,
    input  logic [15:0] sample_data,
    output logic [2:0]  sample_ch,
    output logic        sample_rd,
    output logic        cfg_wr,
    output logic [2:0]  cfg_addr,
    output logic [7:0]  cfg_data,
    input  logic [2:0]  cfg_rd_addr,
    output logic [7:0]  cfg_rd_data,
    output logic        data_mode
);
    localparam int GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

    logic w_rise;
    logic w_fall;

    adc733_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk (
        .i_clk  (clk),
        .i_rst_l(rst_l),
        .i_se   (SE),
        .o_sclk (SCLK),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    rx_state_t   r_rx_st, w_rx_nxt;
    logic [3:0]  r_rx_cnt;
    logic [14:0] r_rx_sh;
    logic [15:0] w_rx_word;
    logic        w_rx_done;
    logic        w_unused_bits;
    logic [7:0]  r_regs [8];
    logic        r_cfg_wr;
    logic [2:0]  r_cfg_addr;
    logic [7:0]  r_cfg_data;
    logic        r_data_mode;

    assign w_rx_word     = {r_rx_sh, SDI};
    assign w_unused_bits = ^w_rx_word[13:11];

    always_comb begin
        w_rx_nxt  = r_rx_st;
        w_rx_done = 1'b0;
        if (!SE) begin
            w_rx_nxt = RX_IDLE;
        end else if (w_fall) begin
            if (r_rx_st == RX_IDLE) begin
                if (SDIFS && !r_data_mode) w_rx_nxt = RX_SHIFT;
            end else if (r_rx_cnt == 4'd15) begin
                w_rx_nxt  = RX_IDLE;
                w_rx_done = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) r_rx_st <= RX_IDLE;
        else        r_rx_st <= w_rx_nxt;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_rx_cnt    <= '0;
            r_rx_sh     <= '0;
            r_cfg_wr    <= 1'b0;
            r_cfg_addr  <= '0;
            r_cfg_data  <= '0;
            r_data_mode <= 1'b0;
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
        end else begin
            r_cfg_wr <= 1'b0;
            if (w_fall && r_rx_st == RX_SHIFT) begin
                r_rx_sh  <= w_rx_word[14:0];
                r_rx_cnt <= r_rx_cnt + 4'd1;
            end else if (w_fall) begin
                r_rx_cnt <= 4'd0;
            end
            // Write words carry RW=0; RW=1 (read request) words are dropped.
            if (w_rx_done) begin
                if (w_rx_word[CW_CD_BIT]) begin
                    if (!w_rx_word[CW_RW_BIT]) begin
                        r_regs[w_rx_word[CW_ADDR_HI:CW_ADDR_LO]] <= w_rx_word[CW_DATA_HI:CW_DATA_LO];
                        r_cfg_wr   <= 1'b1;
                        r_cfg_addr <= w_rx_word[CW_ADDR_HI:CW_ADDR_LO];
                        r_cfg_data <= w_rx_word[CW_DATA_HI:CW_DATA_LO];
                    end
                end else begin
                    r_data_mode <= 1'b1;
                end
            end
        end
    end

    tx_state_t        r_tx_st, w_tx_nxt;
    logic             w_launch;
    logic [3:0]       r_tx_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [15:0]      r_tx_sh;
    logic [15:0]      w_sample;
    logic             r_sdofs;
    logic             r_sdo;
    logic             r_sample_rd;
    logic [2:0]       r_ch;

    always_comb begin
        w_tx_nxt = r_tx_st;
        w_launch = 1'b0;
        if (!SE) begin
            w_tx_nxt = TX_IDLE;
        end else if (w_rise) begin
            case (r_tx_st)
                TX_IDLE: if (r_data_mode) begin
                    w_tx_nxt = TX_SYNC;
                    w_launch = 1'b1;
                end
                TX_SYNC: w_tx_nxt = TX_DATA;
                TX_DATA: if (r_tx_cnt == 4'd15) w_tx_nxt = TX_GAP;
                TX_GAP:  if (r_gap_cnt == GAP_W'(FRAME_GAP - 1)) begin
                    w_tx_nxt = TX_SYNC;
                    w_launch = 1'b1;
                end
                default: w_tx_nxt = TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) r_tx_st <= TX_IDLE;
        else        r_tx_st <= w_tx_nxt;
    end

`ifdef ADC733_EMU_RAMP_EN
    logic [15:0] r_ramp [NUM_CH];
    logic        w_unused_sample;

    assign w_unused_sample = ^sample_data;
    assign w_sample        = r_ramp[r_ch];

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < NUM_CH; i++) r_ramp[i] <= '0;
        end else if (r_sample_rd) begin
            r_ramp[r_ch] <= r_ramp[r_ch] + 16'd1;
        end
    end
`else
    assign w_sample = sample_data;
`endif

    // sample_rd rises with SDOFS; the sample is latched in that cycle, well before the first data rise.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_sdofs     <= 1'b0;
            r_sdo       <= 1'b0;
            r_sample_rd <= 1'b0;
            r_ch        <= '0;
            r_tx_cnt    <= '0;
            r_gap_cnt   <= '0;
            r_tx_sh     <= '0;
        end else begin
            r_sample_rd <= w_launch;
            r_sdofs     <= (w_tx_nxt == TX_SYNC);
            if (r_sample_rd) r_tx_sh <= w_sample;
            if (w_launch && r_tx_st == TX_GAP)
                r_ch <= (r_ch == 3'(NUM_CH - 1)) ? 3'd0 : r_ch + 3'd1;
            if (w_tx_nxt != TX_DATA) begin
                r_sdo <= 1'b0;
            end else if (w_rise) begin
                r_sdo   <= r_tx_sh[15];
                r_tx_sh <= {r_tx_sh[14:0], 1'b0};
            end
            if (w_rise) begin
                r_tx_cnt  <= (r_tx_st == TX_DATA) ? r_tx_cnt + 4'd1 : 4'd0;
                r_gap_cnt <= (r_tx_st == TX_GAP) ? r_gap_cnt + 1'b1 : '0;
            end
        end
    end

    assign SDOFS       = r_sdofs;
    assign SDO         = r_sdo;
    assign sample_rd   = r_sample_rd;
    assign sample_ch   = r_ch;
    assign cfg_wr      = r_cfg_wr;
    assign cfg_addr    = r_cfg_addr;
    assign cfg_data    = r_cfg_data;
    assign cfg_rd_data = r_regs[cfg_rd_addr];
    assign data_mode   = r_data_mode;

endmodule

// File: tb/tb_adc733_emu.sv
// Scoreboard bench for adc733_emu: randomized control words and sample tables against a frame-level model.
// Honours ADC733_EMU_RAMP_EN to switch the expected sample source to per-channel ramps.
module tb_adc733_emu;
    localparam int SCLK_DIV  = 2;
    localparam int FRAME_GAP = 4;
    localparam int NUM_CH    = 6;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        SE;
    logic        SCLK;
    logic        SDIFS;
    logic        SDI;
    logic        SDOFS;
    logic        SDO;
    logic [15:0] sample_data;
    logic [2:0]  sample_ch;
    logic        sample_rd;
    logic        cfg_wr;
    logic [2:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic [2:0]  cfg_rd_addr;
    logic [7:0]  cfg_rd_data;
    logic        data_mode;

    always #5 clk = ~clk;

    adc733_emu #(.SCLK_DIV(SCLK_DIV), .FRAME_GAP(FRAME_GAP), .NUM_CH(NUM_CH)) dut (
        .clk(clk), .rst_l(rst_l), .SE(SE), .SCLK(SCLK), .SDIFS(SDIFS), .SDI(SDI),
        .SDOFS(SDOFS), .SDO(SDO), .sample_data(sample_data), .sample_ch(sample_ch),
        .sample_rd(sample_rd), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_rd_addr(cfg_rd_addr), .cfg_rd_data(cfg_rd_data), .data_mode(data_mode)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] chan_tbl [8];
    logic [7:0]  m_regs   [8];
    logic [15:0] m_ramp   [8];
    int          m_ch = 0;
    logic [10:0] cfg_q [$];
    logic [18:0] frm_q [$];

    assign sample_data = chan_tbl[sample_ch];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic abort_run(input string name);
        miscompares++;
        $display("FAIL %s: timed out", name);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    endtask

    task automatic sclk_rise();
        logic p;
        int   n = 0;
        forever begin
            p = SCLK;
            @(posedge clk); #1;
            if (!p && SCLK) break;
            if (++n > 200) abort_run("sclk_rise");
        end
    endtask

    task automatic send_word(input logic [15:0] w, input int nbits, input bit noisy);
        sclk_rise();
        SDIFS = 1'b1;
        SDI   = 1'($urandom);
        for (int i = 0; i < nbits; i++) begin
            sclk_rise();
            SDIFS = noisy ? 1'($urandom) : 1'b0;
            SDI   = w[15-i];
        end
        if (nbits == 16) begin
            sclk_rise();
            SDIFS = 1'b0;
            SDI   = 1'b0;
        end
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [7:0] d, input bit noisy);
        logic [15:0] w;
        w = {2'b10, 3'($urandom), a, d};
        cfg_q.push_back({a, d});
        m_regs[a] = d;
        send_word(w, 16, noisy);
    endtask

    task automatic check_rd(input logic [2:0] a);
        cfg_rd_addr = a;
        #1;
        check($sformatf("rd_reg%0d", a), 32'(cfg_rd_data), 32'(m_regs[a]));
    endtask

    task automatic push_frames(input int n);
        logic [15:0] d;
        for (int i = 0; i < n; i++) begin
`ifdef ADC733_EMU_RAMP_EN
            d = m_ramp[m_ch];
            m_ramp[m_ch] = m_ramp[m_ch] + 16'd1;
`else
            d = chan_tbl[m_ch];
`endif
            frm_q.push_back({3'(m_ch), d});
            m_ch = (m_ch + 1) % NUM_CH;
        end
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (frm_q.size() != 0) begin
            @(posedge clk); #1;
            if (++n > limit) begin
                check("frame_drain", 32'(frm_q.size()), 32'd0);
                frm_q.delete();
            end
        end
    endtask

    // Monitor: control-register writes and transmitted frames against the queues.
    logic        mp_sclk = 1'b0, mp_sdofs = 1'b0, mp_cfg_wr = 1'b0, mcol = 1'b0, mfs_bad = 1'b0;
    int          mbits = 0;
    logic [15:0] msh;
    logic [2:0]  mch;
    logic [18:0] mexp;
    logic [10:0] cexp;

    always @(negedge clk) begin
        if (rst_l === 1'b1 && cfg_wr) begin
            check("cfg_wr_pulse", 32'(mp_cfg_wr), 32'd0);
            if (cfg_q.size() == 0) check("cfg_wr_unexpected", {21'd0, cfg_addr, cfg_data}, 32'h7ff);
            else begin
                cexp = cfg_q.pop_front();
                check("cfg_wr_addr_data", {21'd0, cfg_addr, cfg_data}, {21'd0, cexp});
            end
        end
        if (rst_l === 1'b1 && sample_rd)
            check("sample_rd_with_sdofs", {30'd0, SDOFS, mp_sdofs}, 32'd2);
        if (!SE || !rst_l) begin
            mcol = 1'b0;
        end else if (mp_sclk && !SCLK) begin
            if (mcol) begin
                msh = {msh[14:0], SDO};
                if (SDOFS) mfs_bad = 1'b1;
                if (++mbits == 16) begin
                    mcol = 1'b0;
                    if (frm_q.size() == 0) check("frame_unexpected", {13'd0, mch, msh}, 32'hffffffff);
                    else begin
                        mexp = frm_q.pop_front();
                        check("frame_ch_data_fs", {12'd0, mfs_bad, mch, msh}, {13'd0, mexp});
                    end
                end
            end else if (SDOFS) begin
                mcol    = 1'b1;
                mbits   = 0;
                mch     = sample_ch;
                mfs_bad = SDO;
            end
        end
        mp_sclk   = SCLK;
        mp_sdofs  = SDOFS;
        mp_cfg_wr = cfg_wr;
    end

    initial begin
        int          n;
        logic [2:0]  a;
        rst_l = 1'b0;
        SE = 1'b1;
        SDIFS = 1'b0;
        SDI = 1'b0;
        cfg_rd_addr = 3'd0;
        for (int i = 0; i < 8; i++) begin
            chan_tbl[i] = 16'($urandom);
            m_regs[i]   = 8'd0;
            m_ramp[i]   = 16'd0;
        end
        chan_tbl[0] = 16'hA5C3;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {12'd0, SCLK, SDOFS, SDO, sample_rd, cfg_wr, cfg_addr, cfg_data, data_mode, sample_ch},
              32'd0);
        check("reset_rd_data", 32'(cfg_rd_data), 32'd0);
        @(negedge clk);
        rst_l = 1'b1;

        sclk_rise();
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(SCLK && n > 1) && n < 50);
        check("sclk_period", 32'(n), 32'(2 * SCLK_DIV));

        write_reg(3'd3, 8'h55, 1'b0);
        check_rd(3'd3);
        for (int i = 0; i < 8; i++) begin
            a = 3'(i);
            write_reg(a, 8'($urandom), 1'b1);
            check_rd(a);
        end
        send_word({2'b11, 14'($urandom)}, 16, 1'b0);
        for (int i = 0; i < 8; i++) check_rd(3'(i));

        send_word(16'h8A77 ^ {8'h00, 8'($urandom)}, 7, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        SE = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        SE = 1'b1;
        write_reg(3'd2, 8'hC4, 1'b0);
        check_rd(3'd2);

        check("data_mode_before", 32'(data_mode), 32'd0);
        push_frames(8);
        send_word(16'h0000, 16, 1'b0);
        check("data_mode_after", 32'(data_mode), 32'd1);
        wait_drain(4000);

        n = 0;
        while (!SDOFS) begin
            @(posedge clk); #1;
            if (++n > 400) abort_run("sdofs_wait");
        end
        repeat (30) @(posedge clk);
        #1;
        SE = 1'b0;
`ifdef ADC733_EMU_RAMP_EN
        m_ramp[m_ch] = m_ramp[m_ch] + 16'd1;
`endif
        repeat (10) @(posedge clk);
        #1;
        check("abort_state", {27'd0, SDOFS, SDO, sample_ch}, {27'd0, 2'b00, 3'(m_ch)});
        check("abort_data_mode", 32'(data_mode), 32'd1);
        SE = 1'b1;
        push_frames(7);
        send_word(16'h8111, 16, 1'b0);
        wait_drain(4000);
        SE = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("cfg_queue_empty", 32'(cfg_q.size()), 32'd0);
        for (int i = 0; i < 8; i++) check_rd(3'(i));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
